// File: rtl/scratch_pad_client_pkg.sv
// Shared defaults for scratch-pad clients: data/address widths, port count and
// return-buffer sizing helper.
package scratch_pad_client_pkg;

    localparam int SP_WIDTH      = 64;
    localparam int SP_ADDR_WIDTH = 12;
    localparam int SP_NUM_PORTS  = 4;
    localparam int SP_RET_DEPTH  = 4;

    // Counters must hold the value DEPTH itself, hence one bit beyond the pointer width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/scratch_pad_client_fifo.sv
// First-word fall-through FIFO holding read data returned by the scratch pad
// until the engine consumes it.
module scratch_pad_client_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 do_push, do_pop;

    always_comb begin
        // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
        do_pop   = pop & (count_q != '0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push & ((count_q != FULL) | do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/scratch_pad_client.sv
// Engine-side initiator for one scratch-pad port: valid/ready command channel,
// credit-limited reads and a buffered, in-order read-response channel.
module scratch_pad_client
    import scratch_pad_client_pkg::*;
#(
    parameter int WIDTH      = SP_WIDTH,
    parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
    parameter int RET_DEPTH  = SP_RET_DEPTH,
    parameter int CNT_WIDTH  = cnt_width(RET_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_data,
    output logic                  cmd_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  rsp_ready,
    output logic                  sp_rd_en,
    output logic                  sp_wr_en,
    output logic [ADDR_WIDTH-1:0] sp_addr,
    output logic [WIDTH-1:0]      sp_d,
    input  logic [WIDTH-1:0]      sp_q,
    input  logic                  sp_valid,
    input  logic                  sp_full,
    output logic                  sp_stall,
    output logic                  idle,
    output logic                  err
);

    localparam logic [CNT_WIDTH-1:0] FULL      = CNT_WIDTH'(RET_DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   DEPTH_SUM = (CNT_WIDTH + 1)'(RET_DEPTH);

    logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] fifo_count;
    logic [CNT_WIDTH:0]   in_flight;
    logic                 credit_ok;
    logic                 ret, push, pop;

    // Every read either still in flight or already buffered holds one FIFO slot.
    assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok = in_flight < DEPTH_SUM;

    assign sp_addr   = cmd_addr;
    assign sp_d      = cmd_data;
    assign sp_wr_en  = cmd_valid & cmd_we & ~sp_full;
    assign sp_rd_en  = cmd_valid & ~cmd_we & ~sp_full & credit_ok;
    assign cmd_ready = ~sp_full & (cmd_we | credit_ok);

    assign sp_stall  = (fifo_count == FULL);
    assign ret       = sp_valid & ~sp_stall;
    // Data arriving with nothing outstanding is unsolicited and is dropped.
    assign push      = ret & (outstanding_q != '0);
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign idle      = (outstanding_q == '0) & (fifo_count == '0);
    assign err       = err_q;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({sp_rd_en, push})
            2'b10:   outstanding_d = outstanding_q + ONE;
            2'b01:   outstanding_d = outstanding_q - ONE;
            default: outstanding_d = outstanding_q;
        endcase
        err_d = err_q | (sp_valid & (outstanding_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    scratch_pad_client_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (RET_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ret_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (sp_q),
        .dout  (rsp_data),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_scratch_pad_client.sv
// Bench for scratch_pad_client: behavioural scratch-pad port with variable read
// latency, expected read data queued on issue and compared on consumption.
module tb_scratch_pad_client;

    localparam int W  = 64;
    localparam int AW = 12;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_we, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_data;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          sp_rd_en, sp_wr_en, sp_stall, sp_valid, sp_full;
    logic [AW-1:0] sp_addr;
    logic [W-1:0]  sp_d, sp_q;
    logic          idle, err;

    always #5 clk = ~clk;

    scratch_pad_client #(
        .WIDTH(W), .ADDR_WIDTH(AW), .RET_DEPTH(D), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .sp_rd_en(sp_rd_en), .sp_wr_en(sp_wr_en), .sp_addr(sp_addr), .sp_d(sp_d),
        .sp_q(sp_q), .sp_valid(sp_valid), .sp_full(sp_full), .sp_stall(sp_stall),
        .idle(idle), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scratch-pad port model and scoreboard
    typedef struct {
        logic [W-1:0] data;
        int           due;
    } rd_t;

    logic [W-1:0] mem [4096];
    rd_t          pipe[$];
    logic [W-1:0] exp_q[$];
    int           cyc = 0;
    int           lat = 2;
    logic         model_valid;
    logic         inject;
    int           wr_pulses = 0;
    int           rd_accepts = 0;
    int           rsp_cnt = 0;
    int           mark = -1;
    int           first_rsp_cyc = 0;
    int           last_rsp_cyc = 0;
    logic [W-1:0] last_rsp = '0;

    assign sp_valid = model_valid | inject;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst || pipe.size() == 0) begin
            model_valid = 1'b0;
        end else if (pipe[0].due <= cyc) begin
            model_valid = 1'b1;
            sp_q        = pipe[0].data;
        end else begin
            model_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pipe.delete();
            exp_q.delete();
        end else begin
            check("cnt_bound", 64'((dut.outstanding_q > 3'd4) || (dut.fifo_count > 3'd4)), 64'd0);
            if (sp_wr_en) begin
                mem[sp_addr] = sp_d;
                wr_pulses++;
            end
            if (sp_rd_en) begin
                pipe.push_back('{data: mem[sp_addr], due: cyc + lat});
                exp_q.push_back(mem[sp_addr]);
                rd_accepts++;
            end
            if (model_valid && !sp_stall) void'(pipe.pop_front());
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
                else check("rsp_data", rsp_data, exp_q.pop_front());
                if (rsp_cnt == mark) first_rsp_cyc = cyc;
                last_rsp     = rsp_data;
                last_rsp_cyc = cyc;
                rsp_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            sample();
            if (rsp_cnt >= target) break;
            tick();
        end
        check("wait_rsp", 64'(rsp_cnt), 64'(target));
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            sample();
            if (idle) break;
            tick();
        end
        check("wait_idle", 64'(idle), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_a, base_r, a, cycles;
        rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; sp_full = 1'b0; inject = 1'b0; model_valid = 1'b0; sp_q = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        check("rst_stall", 64'(sp_stall), 64'd0);
        tick(); tick();
        rst = 1'b0;

        // Write 42 to address 0, read it back
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = '0; cmd_data = 64'd42;
        sample();
        check("wr_ready", 64'(cmd_ready), 64'd1);
        check("wr_en", 64'(sp_wr_en), 64'd1);
        tick();
        cmd_valid = 1'b0; cmd_we = 1'b0;
        sample();
        tick();
        cmd_valid = 1'b1;
        sample();
        check("rd_en", 64'(sp_rd_en), 64'd1);
        tick();
        cmd_valid = 1'b0;
        wait_rsp(1, 20);
        check("wr_pulses", 64'(wr_pulses), 64'd1);
        check("rd_data42", last_rsp, 64'd42);
        wait_idle(20);
        tick();

        // Preload addresses 0..15 with value = address
        for (int i = 0; i < 16; i++) begin
            cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = AW'(i); cmd_data = 64'(i);
            tick();
        end
        cmd_valid = 1'b0; cmd_we = 1'b0;
        check("preload_wr", 64'(wr_pulses), 64'd17);

        // Back-pressure from the port
        base_r = rsp_cnt;
        for (int i = 0; i < 5; i++) begin
            sp_full = 1'b1; cmd_valid = 1'b1; cmd_addr = AW'(5); cmd_we = (i % 2) == 1;
            sample();
            check("bp_blocked", 64'({cmd_ready, sp_rd_en, sp_wr_en}), 64'd0);
            tick();
        end
        sp_full = 1'b0; cmd_we = 1'b0;
        sample();
        check("bp_issue", 64'(sp_rd_en), 64'd1);
        tick();
        cmd_valid = 1'b0;
        wait_rsp(base_r + 1, 20);
        check("bp_data", last_rsp, 64'd5);
        wait_idle(20);
        tick();

        // Credit exhaustion with the engine stalled
        rsp_ready = 1'b0;
        base_a = rd_accepts; base_r = rsp_cnt; a = 1;
        cmd_valid = 1'b1; cmd_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_addr = AW'(a);
            sample();
            if (sp_rd_en) a++;
            tick();
        end
        check("credit_accepts4", 64'(rd_accepts - base_a), 64'd4);
        cmd_addr = AW'(a);
        for (int k = 0; k < 20; k++) begin
            sample();
            if (sp_stall) break;
            tick();
        end
        check("stall_full", 64'(sp_stall), 64'd1);
        check("credit_ready_low", 64'(cmd_ready), 64'd0);
        check("rsp_held", 64'(rsp_valid), 64'd1);
        check("still_4", 64'(rd_accepts - base_a), 64'd4);
        tick();
        rsp_ready = 1'b1;
        sample();
        check("pop_cycle_ready", 64'(cmd_ready), 64'd0);
        tick();
        rsp_ready = 1'b0;
        sample();
        check("refill_rd", 64'(sp_rd_en), 64'd1);
        tick();
        cmd_valid = 1'b0;
        check("credit_accepts5", 64'(rd_accepts - base_a), 64'd5);
        check("one_pop", 64'(rsp_cnt - base_r), 64'd1);
        rsp_ready = 1'b1;
        wait_rsp(base_r + 5, 40);
        check("credit_last", last_rsp, 64'd5);
        wait_idle(20);
        tick();

        // Streaming 16 reads with the engine always ready
        base_r = rsp_cnt; mark = rsp_cnt; a = 0; cycles = 0;
        while (a < 16 && cycles < 64) begin
            cmd_valid = 1'b1; cmd_addr = AW'(a);
            sample();
            if (sp_rd_en) a++;
            cycles++;
            tick();
        end
        cmd_valid = 1'b0;
        check("stream_issue_cycles", 64'(cycles), 64'd16);
        wait_rsp(base_r + 16, 60);
        check("stream_span", 64'(last_rsp_cyc - first_rsp_cyc), 64'd15);
        check("stream_last", last_rsp, 64'd15);
        mark = -1;
        wait_idle(20);
        tick();

        // Unsolicited return data
        inject = 1'b1;
        sample();
        check("err_before_edge", 64'(err), 64'd0);
        tick();
        inject = 1'b0;
        sample();
        check("err_set", 64'(err), 64'd1);
        check("unsol_no_rsp", 64'(rsp_valid), 64'd0);
        tick(); tick(); tick();
        sample();
        check("err_sticky", 64'(err), 64'd1);
        check("unsol_idle", 64'(idle), 64'd1);
        tick();

        // Reset with three reads outstanding and one buffered
        lat = 10; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'(7);
        sample();
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sample();
            if (rsp_valid) break;
            tick();
        end
        check("buffered", 64'(rsp_valid), 64'd1);
        tick();
        base_a = rd_accepts;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_addr = AW'(8 + i);
            tick();
        end
        cmd_valid = 1'b0;
        check("three_out", 64'(rd_accepts - base_a), 64'd3);
        sample();
        check("pre_rst_busy", 64'(idle), 64'd0);
        check("pre_rst_err", 64'(err), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_idle", 64'(idle), 64'd1);
        check("mid_rst_err", 64'(err), 64'd0);
        tick(); tick();
        rst = 1'b0; lat = 2;
        sample();
        check("post_rst_idle", 64'(idle), 64'd1);
        tick();

        // Recovery read after reset
        base_r = rsp_cnt; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_addr = AW'(3);
        sample();
        tick();
        cmd_valid = 1'b0;
        wait_rsp(base_r + 1, 20);
        check("recover_data", last_rsp, 64'd3);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
